// File: rtl/normalizer.sv
// Left-normalizes an adder-stage mantissa one bit per clock, decrementing the exponent per shift.
// Latency k+1 clocks for k leading zeros (max MANT_W); single operand in flight, held in DONE until out_ready.
module normalizer #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mantis_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mantis_out,
  output logic [CNT_W-1:0]  shift_count,
  output logic              zero,
  output logic              underflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The output registers double as the working registers; they are only
  // qualified by out_valid once the FSM reaches DONE, where they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sign_out    <= 1'b0;
      exp_out     <= '0;
      mantis_out  <= '0;
      shift_count <= '0;
      zero        <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_out    <= sign_in;
            exp_out     <= exp_in;
            mantis_out  <= mantis_in;
            shift_count <= '0;
            zero        <= 1'b0;
            underflow   <= 1'b0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (mantis_out == '0) begin
            zero    <= 1'b1;
            exp_out <= '0;
            state   <= DONE;
          end else if (mantis_out[MANT_W-1]) begin
            state <= DONE;
          end else if (exp_out == '0) begin
            // Exponent exhausted: stop without shifting so exp never wraps.
            underflow <= 1'b1;
            state     <= DONE;
          end else begin
            mantis_out  <= {mantis_out[MANT_W-2:0], 1'b0};
            exp_out     <= exp_out - EXP_W'(1);
            shift_count <= shift_count + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizer.sv
// Directed bench for normalizer: hand-computed vectors checked with immediate assertions.
module tb_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [27:0] mantis_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [27:0] mantis_out;
  logic [4:0]  shift_count;
  logic        zero;
  logic        underflow;

  int n_cmp = 0;
  int n_err = 0;

  normalizer #(.MANT_W(28), .EXP_W(8), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mantis_in(mantis_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .mantis_out(mantis_out),
    .shift_count(shift_count), .zero(zero), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Present an operand, accept it, then wait for out_valid and check the result.
  task automatic run_case(input string tag, input logic s, input logic [7:0] e,
                          input logic [27:0] m, input int lat, input logic [27:0] em,
                          input logic [7:0] ee, input logic [4:0] ec,
                          input logic ez, input logic eu);
    int cyc;
    check({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1; sign_in = s; exp_in = e; mantis_in = m;
    step();
    in_valid = 1'b0; exp_in = 8'hff; mantis_in = 28'hfffffff; sign_in = ~s;
    cyc = 0;
    while (cyc < 60) begin
      step();
      cyc++;
      if (out_valid) break;
    end
    check({tag, ".latency"},     cyc, lat);
    check({tag, ".mantis_out"},  mantis_out, em);
    check({tag, ".exp_out"},     exp_out, ee);
    check({tag, ".shift_count"}, shift_count, ec);
    check({tag, ".zero"},        zero, ez);
    check({tag, ".underflow"},   underflow, eu);
    check({tag, ".sign_out"},    sign_out, s);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    check({tag, ".hs_in_ready"},  in_ready, 1);
    check({tag, ".hs_out_valid"}, out_valid, 0);
  endtask

  initial begin
    logic [27:0] hm;
    logic [7:0]  he;
    logic [4:0]  hc;
    logic        seen;

    rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; mantis_in = '0;
    out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst.out_valid",   out_valid, 0);
    check("rst.mantis_out",  mantis_out, 0);
    check("rst.exp_out",     exp_out, 0);
    check("rst.shift_count", shift_count, 0);
    check("rst.zero",        zero, 0);
    check("rst.underflow",   underflow, 0);
    check("rst.sign_out",    sign_out, 0);
    check("rst.in_ready",    in_ready, 1);

    run_case("normal", 1'b0, 8'h80, 28'h8000000, 1, 28'h8000000, 8'h80, 5'd0, 1'b0, 1'b0);
    handshake("normal");
    run_case("deep", 1'b0, 8'h80, 28'h0000010, 24, 28'h8000000, 8'h69, 5'd23, 1'b0, 1'b0);
    handshake("deep");
    run_case("zero", 1'b1, 8'h55, 28'h0000000, 1, 28'h0000000, 8'h00, 5'd0, 1'b1, 1'b0);
    handshake("zero");
    run_case("uflow", 1'b0, 8'h03, 28'h0100000, 4, 28'h0800000, 8'h00, 5'd3, 1'b0, 1'b1);
    handshake("uflow");
    run_case("exp0norm", 1'b1, 8'h00, 28'h4000000, 1, 28'h4000000, 8'h00, 5'd0, 1'b0, 1'b1);
    handshake("exp0norm");

    // Backpressure: result must hold for 5 clocks while a new operand waits.
    out_ready = 1'b0;
    run_case("bp", 1'b1, 8'h10, 28'h0300000, 7, 28'hc000000, 8'h0a, 5'd6, 1'b0, 1'b0);
    hm = mantis_out; he = exp_out; hc = shift_count;
    in_valid = 1'b1; sign_in = 1'b0; exp_in = 8'h40; mantis_in = 28'h2000000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp.hold_valid",    out_valid, 1);
      check("bp.hold_in_ready", in_ready, 0);
      check("bp.hold_mantis",   mantis_out, hm);
      check("bp.hold_exp",      exp_out, he);
      check("bp.hold_cnt",      shift_count, hc);
    end
    handshake("bp");
    step();
    in_valid = 1'b0;
    check("bp.accepted", in_ready, 0);
    step(); step(); step();
    check("bp2.out_valid",  out_valid, 1);
    check("bp2.mantis_out", mantis_out, 28'h8000000);
    check("bp2.exp_out",    exp_out, 8'h3e);
    check("bp2.shift_cnt",  shift_count, 2);
    check("bp2.sign_out",   sign_out, 0);
    step();
    check("bp2.idle", in_ready, 1);

    // Reset mid-SHIFT abandons the operand.
    in_valid = 1'b1; sign_in = 1'b1; exp_in = 8'h80; mantis_in = 28'h0000010;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst.out_valid",   out_valid, 0);
    check("mrst.in_ready",    in_ready, 1);
    check("mrst.mantis_out",  mantis_out, 0);
    check("mrst.exp_out",     exp_out, 0);
    check("mrst.shift_count", shift_count, 0);
    check("mrst.sign_out",    sign_out, 0);
    check("mrst.flags",       {zero, underflow}, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("mrst.no_out_valid", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
